// File: rtl/sm_hex_display_pkg.sv
// Shared definitions for the multiplexed 8-digit seven-segment display driver.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package sm_hex_display_pkg;

    localparam int unsigned DIGITS = 8;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    typedef logic [6:0] seg_t;

    // Entry [n] is the glyph for hex digit n.
    localparam seg_t [15:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/sm_hex_to_seg.sv
// Hex nibble to active-high seven-segment glyph.
module sm_hex_to_seg
    import sm_hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       pattern
);

    assign pattern = HEX_SEG[nibble];

endmodule

// File: rtl/sm_hex_display.sv
// Time-multiplexed 8-digit hex display: shadow register, digit scan with blank
// interval per slot, optional leading-zero suppression, registered pins.
module sm_hex_display
    import sm_hex_display_pkg::*;
#(
    parameter int unsigned SCAN_SHIFT   = 10,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter bit          LZ_BLANK     = 1'b1,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       data,
    input  logic              update,
    input  logic              enable,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] anode
);

    localparam int unsigned CW = SCAN_SHIFT + 3;
    localparam int unsigned DW = $clog2(DIGITS);

    localparam logic [6:0]        SEG_OFF   = {7{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] ANODE_OFF = {DIGITS{ACTIVE_LOW}};

    logic [CW-1:0]         cntr_q;
    logic [31:0]           shadow_q;
    logic [DW-1:0]         digit;
    logic [SCAN_SHIFT-1:0] slot_pos;
    logic                  blank;
    logic [DW-1:0]         lz_top;
    logic [3:0]            nibble;
    seg_t                  pattern;
    logic [6:0]            seg_on, seg_d, seg_q;
    logic [DIGITS-1:0]     anode_on, anode_d, anode_q;
    logic                  dp_q;

    assign digit    = cntr_q[CW-1:SCAN_SHIFT];
    assign slot_pos = cntr_q[SCAN_SHIFT-1:0];
    assign blank    = 32'(slot_pos) < BLANK_CYCLES;
    assign nibble   = shadow_q[{digit, 2'b00} +: 4];

    // Highest nonzero nibble; stays 0 for an all-zero shadow so digit 0 still shows.
    always_comb begin
        lz_top = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (shadow_q[4*i +: 4] != 4'h0) lz_top = DW'(i);
        end
    end

    sm_hex_to_seg u_hex_to_seg (
        .nibble  (nibble),
        .pattern (pattern)
    );

    always_comb begin
        seg_on   = pattern;
        anode_on = DIGITS'(1) << digit;
        if (blank) begin
            seg_on   = '0;
            anode_on = '0;
        end else if (LZ_BLANK && (digit > lz_top)) begin
            seg_on   = '0;
        end
        seg_d   = seg_on ^ SEG_OFF;
        anode_d = anode_on ^ ANODE_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntr_q   <= '0;
            shadow_q <= '0;
            seg_q    <= SEG_OFF;
            anode_q  <= ANODE_OFF;
            dp_q     <= ACTIVE_LOW;
        end else begin
            if (enable) cntr_q <= cntr_q + CW'(1);
            if (update) shadow_q <= data;
            seg_q   <= seg_d;
            anode_q <= anode_d;
            dp_q    <= ACTIVE_LOW;
        end
    end

    assign seg   = seg_q;
    assign anode = anode_q;
    assign dp    = dp_q;

endmodule

// File: tb/tb_sm_hex_display.sv
// Bench for sm_hex_display: two instances (leading-zero blanking on/off) with a
// small scan model feeding a one-deep expected-value queue, plus directed pin checks.
module tb_sm_hex_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic        update;
    logic        enable;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [7:0] anode_a, anode_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0] seg_lz;
        logic [6:0] seg_nolz;
        logic [7:0] anode;
    } exp_t;

    exp_t sb[$];

    logic [6:0] m_cnt;
    logic [31:0] m_shadow;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    // Pins for 32'h12345678, slot 0..7
    logic [6:0] exp_scan [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    logic [6:0] exp_a5_lz [8] = '{7'h12, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] exp_a5_nolz [8] = '{7'h12, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    always #5 clk = ~clk;

    sm_hex_display #(
        .SCAN_SHIFT   (4),
        .BLANK_CYCLES (2),
        .LZ_BLANK     (1'b1),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .data   (data),
        .update (update),
        .enable (enable),
        .seg    (seg_a),
        .dp     (dp_a),
        .anode  (anode_a)
    );

    sm_hex_display #(
        .SCAN_SHIFT   (4),
        .BLANK_CYCLES (2),
        .LZ_BLANK     (1'b0),
        .ACTIVE_LOW   (1'b1)
    ) dut_nolz (
        .clk    (clk),
        .rst_n  (rst_n),
        .data   (data),
        .update (update),
        .enable (enable),
        .seg    (seg_b),
        .dp     (dp_b),
        .anode  (anode_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [6:0] cnt, input logic [31:0] sh);
        exp_t        e;
        logic [31:0] t;
        int          top;
        int          slot;
        logic [3:0]  nib;
        slot = int'(cnt[6:4]);
        top  = 0;
        t    = sh;
        while (t > 32'hF) begin
            t = t >> 4;
            top++;
        end
        if (cnt[3:0] < 4'd2) begin
            e.seg_lz   = 7'h7F;
            e.seg_nolz = 7'h7F;
            e.anode    = 8'hFF;
        end else begin
            nib        = sh[4*slot +: 4];
            e.seg_nolz = ~hex_tab[nib];
            e.seg_lz   = (slot > top) ? 7'h7F : e.seg_nolz;
            e.anode    = ~(8'h01 << slot);
        end
        return e;
    endfunction

    task automatic check_off(input string tag);
        check({tag, "_seg"}, {1'b0, seg_a}, 8'h7F);
        check({tag, "_seg_nolz"}, {1'b0, seg_b}, 8'h7F);
        check({tag, "_anode"}, anode_a, 8'hFF);
        check({tag, "_dp"}, {7'd0, dp_a}, 8'h01);
    endtask

    // One clock: predicted pins are queued before the edge and compared after it.
    task automatic cycle();
        exp_t e;
        sb.push_back(model(m_cnt, m_shadow));
        @(posedge clk);
        if (enable) m_cnt = m_cnt + 7'd1;
        if (update) m_shadow = data;
        #1;
        e = sb.pop_front();
        check("sb_seg_lz", {1'b0, seg_a}, {1'b0, e.seg_lz});
        check("sb_seg_nolz", {1'b0, seg_b}, {1'b0, e.seg_nolz});
        check("sb_anode", anode_a, e.anode);
        check("sb_anode_nolz", anode_b, e.anode);
        check("sb_dp", {6'd0, dp_a, dp_b}, 8'h03);
    endtask

    task automatic run_to(input logic [6:0] target);
        int n;
        n = 0;
        while (m_cnt != target && n < 300) begin
            cycle();
            n++;
        end
        check("run_to_reached", {1'b0, m_cnt}, {1'b0, target});
    endtask

    // Advance until the pins reflect counter value `target`.
    task automatic show(input logic [6:0] target);
        run_to(target);
        cycle();
    endtask

    initial begin
        rst_n  = 1'b0;
        update = 1'b1;
        data   = 32'hFFFF_FFFF;
        enable = 1'b1;
        m_cnt    = '0;
        m_shadow = '0;

        // Reset hold with update active.
        repeat (5) begin
            @(posedge clk);
            #1;
            check_off("reset_hold");
        end
        @(negedge clk);
        update = 1'b0;
        rst_n  = 1'b1;
        #1;
        check_off("reset_release");

        show(7'h02);
        check("first_digit_anode", anode_a, 8'hFE);
        check("first_digit_seg", {1'b0, seg_a}, 8'h40);

        // Full scan of 12345678, including blank intervals and wrap.
        data   = 32'h1234_5678;
        update = 1'b1;
        cycle();
        update = 1'b0;
        for (int k = 0; k < 8; k++) begin
            show(7'(k * 16 + 1));
            check("scan_blank_anode", anode_a, 8'hFF);
            check("scan_blank_seg", {1'b0, seg_a}, 8'h7F);
            show(7'(k * 16 + 8));
            check("scan_seg", {1'b0, seg_a}, {1'b0, exp_scan[k]});
            check("scan_anode", anode_a, ~(8'h01 << k));
        end
        repeat (140) cycle();

        // Leading zeros.
        data   = 32'h0000_00A5;
        update = 1'b1;
        cycle();
        update = 1'b0;
        for (int k = 0; k < 8; k++) begin
            show(7'(k * 16 + 8));
            check("lz_seg", {1'b0, seg_a}, {1'b0, exp_a5_lz[k]});
            check("nolz_seg", {1'b0, seg_b}, {1'b0, exp_a5_nolz[k]});
            check("lz_anode", anode_a, ~(8'h01 << k));
        end

        // Zero value: only digit 0 lit when blanking.
        data   = 32'h0;
        update = 1'b1;
        cycle();
        update = 1'b0;
        for (int k = 0; k < 8; k++) begin
            show(7'(k * 16 + 8));
            check("zero_seg", {1'b0, seg_a}, (k == 0) ? 8'h40 : 8'h7F);
            check("zero_seg_nolz", {1'b0, seg_b}, 8'h40);
        end

        // Freeze mid-slot 3, then inside a blank interval.
        data   = 32'h1234_5678;
        update = 1'b1;
        cycle();
        update = 1'b0;
        show(7'h38);
        enable = 1'b0;
        repeat (1000) cycle();
        check("freeze_anode", anode_a, 8'hF7);
        check("freeze_seg", {1'b0, seg_a}, 8'h12);
        enable = 1'b1;
        repeat (20) cycle();
        show(7'h40);
        enable = 1'b0;
        repeat (20) cycle();
        check("freeze_blank_anode", anode_a, 8'hFF);
        check("freeze_blank_seg", {1'b0, seg_a}, 8'h7F);
        enable = 1'b1;

        // Update latency: two edges from the update edge to the pins.
        run_to(7'h04);
        data   = 32'h0000_000F;
        update = 1'b1;
        cycle();
        update = 1'b0;
        check("latency_old", {1'b0, seg_a}, 8'h00);
        cycle();
        check("latency_new", {1'b0, seg_a}, 8'h0E);
        check("latency_anode", anode_a, 8'hFE);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_off("async_reset");
        check("async_reset_anode_nolz", anode_b, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
